// File: rtl/mole_round_controller_if.sv
// Handshake bundle between the round controller, the mole generator, the
// debounced buttons and the display logic.
interface mole_round_controller_if #(
    parameter int NUM_HOLES  = 18,
    parameter int NUM_ROUNDS = 30,
    parameter int LIVES      = 3,
    parameter int SCORE_W    = 10
);
    localparam int LIVES_W = $clog2(LIVES + 1);
    localparam int ROUND_W = $clog2(NUM_ROUNDS + 1);

    logic                 start;
    logic [NUM_HOLES-1:0] buttons;
    logic [NUM_HOLES-1:0] mole_positions;
    logic                 mole_clk;
    logic [NUM_HOLES-1:0] active_moles;
    logic [SCORE_W-1:0]   score;
    logic [LIVES_W-1:0]   lives;
    logic [ROUND_W-1:0]   round;
    logic [7:0]           wrong_presses;
    logic                 busy;
    logic                 game_over;

    modport master (
        output start, buttons, mole_positions,
        input  mole_clk, active_moles, score, lives, round, wrong_presses, busy, game_over
    );

    modport slave (
        input  start, buttons, mole_positions,
        output mole_clk, active_moles, score, lives, round, wrong_presses, busy, game_over
    );
endinterface

// File: rtl/mole_round_controller.sv
// Whack-a-mole game sequencer: paces mole_clk, captures the mole bitmap,
// scores hits, charges lives for escapes and shortens each round's window.
module mole_round_controller #(
    parameter int NUM_HOLES     = 18,
    parameter int NUM_ROUNDS    = 30,
    parameter int LIVES         = 3,
    parameter int UP_START      = 50000000,
    parameter int UP_STEP       = 2500000,
    parameter int UP_MIN        = 12500000,
    parameter int GAP_CYCLES    = 25000000,
    parameter int CAPTURE_DELAY = 2,
    parameter int SCORE_W       = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mole_round_controller_if.slave  bus
);
    localparam int LIVES_W    = $clog2(LIVES + 1);
    localparam int ROUND_W    = $clog2(NUM_ROUNDS + 1);
    localparam int MAX_CNT    = (UP_START > GAP_CYCLES) ? UP_START : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CNT + 1);
    localparam int PC_W       = $clog2(NUM_HOLES + 1);
    localparam int SCORE_MAX  = (1 << SCORE_W) - 1;
    localparam int STEP_FLOOR = UP_MIN + UP_STEP;

    typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     up_len_q, up_len_d;
    logic [NUM_HOLES-1:0] active_q, active_d;
    logic [NUM_HOLES-1:0] btn_prev_q;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [ROUND_W-1:0]   round_q, round_d;
    logic [7:0]           wrong_q, wrong_d;
    logic                 mole_clk_q, mole_clk_d;
    logic                 busy_q, busy_d;
    logic                 game_over_q, game_over_d;
    logic [NUM_HOLES-1:0] new_press, hits;

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_HOLES-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_HOLES; i++) c = c + PC_W'(v[i]);
        return c;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] s,
                                                         input logic [PC_W-1:0]    n);
        int sum;
        sum = int'(s) + int'(n);
        return (sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(sum);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] w);
        return (w == 8'hFF) ? w : w + 8'd1;
    endfunction

    // Compared in int so the subtraction can never wrap below the floor.
    function automatic logic [CNT_W-1:0] next_up_len(input logic [CNT_W-1:0] u);
        if (int'(u) >= STEP_FLOOR) return u - CNT_W'(UP_STEP);
        return CNT_W'(UP_MIN);
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        up_len_d   = up_len_q;
        active_d   = active_q;
        score_d    = score_q;
        lives_d    = lives_q;
        round_d    = round_q;
        wrong_d    = wrong_q;
        mole_clk_d = mole_clk_q;
        new_press  = bus.buttons & ~btn_prev_q;
        hits       = new_press & active_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d    = SHOW;
                    cnt_d      = '0;
                    up_len_d   = CNT_W'(UP_START);
                    active_d   = '0;
                    score_d    = '0;
                    lives_d    = LIVES_W'(LIVES);
                    round_d    = '0;
                    wrong_d    = '0;
                    mole_clk_d = 1'b1;
                end
            end
            SHOW: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CAPTURE_DELAY)) begin
                    active_d = bus.mole_positions;
                end else if (cnt_q > CNT_W'(CAPTURE_DELAY)) begin
                    score_d  = sat_add_score(score_q, popcount(hits));
                    active_d = active_q & ~hits;
                    if ((new_press & ~active_q) != '0) wrong_d = sat_inc8(wrong_q);
                end
                // active_d already reflects a final-cycle hit, so it is the escape set.
                if (cnt_q == up_len_q - CNT_W'(1)) begin
                    if (active_d != '0) lives_d = lives_q - LIVES_W'(1);
                    round_d    = round_q + ROUND_W'(1);
                    up_len_d   = next_up_len(up_len_q);
                    active_d   = '0;
                    cnt_d      = '0;
                    mole_clk_d = 1'b0;
                    state_d    = (lives_d == '0 || round_d == ROUND_W'(NUM_ROUNDS)) ? DONE : GAP;
                end
            end
            GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d    = SHOW;
                    cnt_d      = '0;
                    mole_clk_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d == SHOW) || (state_d == GAP);
        game_over_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            up_len_q    <= CNT_W'(UP_START);
            active_q    <= '0;
            btn_prev_q  <= '0;
            score_q     <= '0;
            lives_q     <= LIVES_W'(LIVES);
            round_q     <= '0;
            wrong_q     <= '0;
            mole_clk_q  <= 1'b0;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            up_len_q    <= up_len_d;
            active_q    <= active_d;
            btn_prev_q  <= bus.buttons;
            score_q     <= score_d;
            lives_q     <= lives_d;
            round_q     <= round_d;
            wrong_q     <= wrong_d;
            mole_clk_q  <= mole_clk_d;
            busy_q      <= busy_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.mole_clk      = mole_clk_q;
    assign bus.active_moles  = active_q;
    assign bus.score         = score_q;
    assign bus.lives         = lives_q;
    assign bus.round         = round_q;
    assign bus.wrong_presses = wrong_q;
    assign bus.busy          = busy_q;
    assign bus.game_over     = game_over_q;
endmodule

// File: tb/tb_mole_round_controller.sv
// Bench for mole_round_controller: directed games with literal expectations
// followed by random play, all tracked by a game-rules model every cycle.
module tb_mole_round_controller;
    localparam int NH    = 18;
    localparam int NR    = 5;
    localparam int LV    = 2;
    localparam int US    = 20;
    localparam int USTEP = 4;
    localparam int UMIN  = 10;
    localparam int GAPC  = 5;
    localparam int CAP   = 2;
    localparam int SW    = 4;
    localparam int SMAX  = (1 << SW) - 1;

    localparam int M_IDLE = 0, M_SHOW = 1, M_GAP = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mole_round_controller_if #(.NUM_HOLES(NH), .NUM_ROUNDS(NR), .LIVES(LV), .SCORE_W(SW)) bus();

    mole_round_controller #(
        .NUM_HOLES(NH), .NUM_ROUNDS(NR), .LIVES(LV), .UP_START(US), .UP_STEP(USTEP),
        .UP_MIN(UMIN), .GAP_CYCLES(GAPC), .CAPTURE_DELAY(CAP), .SCORE_W(SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nchecks = 0;
    int nerrs   = 0;
    bit cmp_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game-rules model: phase + elapsed time, window length in closed form.
    int             m_mode   = M_IDLE;
    int             m_t      = 0;
    int             m_rnd    = 0;
    int             m_lives  = LV;
    int             m_score  = 0;
    int             m_wrong  = 0;
    logic [NH-1:0]  m_active = '0;
    logic [NH-1:0]  m_prev   = '0;

    function automatic int show_len(input int r);
        int v;
        v = US - r * USTEP;
        return (v < UMIN) ? UMIN : v;
    endfunction

    always @(posedge clk) begin : model
        logic [NH-1:0] newp;
        logic [NH-1:0] hits;
        if (rst_n !== 1'b1) begin
            m_mode = M_IDLE; m_t = 0; m_rnd = 0; m_lives = LV;
            m_score = 0; m_wrong = 0; m_active = '0; m_prev = '0;
        end else begin
            newp   = bus.buttons & ~m_prev;
            m_prev = bus.buttons;
            case (m_mode)
                M_IDLE, M_DONE: begin
                    if (bus.start) begin
                        m_mode = M_SHOW; m_t = 0; m_rnd = 0; m_lives = LV;
                        m_score = 0; m_wrong = 0; m_active = '0;
                    end
                end
                M_SHOW: begin
                    if (m_t == CAP) begin
                        m_active = bus.mole_positions;
                    end else if (m_t > CAP) begin
                        hits    = newp & m_active;
                        m_score = m_score + $countones(hits);
                        if (m_score > SMAX) m_score = SMAX;
                        if ((newp & ~m_active) != '0 && m_wrong < 255) m_wrong++;
                        m_active = m_active & ~hits;
                    end
                    if (m_t == show_len(m_rnd) - 1) begin
                        m_rnd++;
                        if (m_active != '0) m_lives--;
                        m_active = '0;
                        m_t      = 0;
                        m_mode   = (m_lives == 0 || m_rnd == NR) ? M_DONE : M_GAP;
                    end else begin
                        m_t++;
                    end
                end
                default: begin
                    if (m_t == GAPC - 1) begin
                        m_mode = M_SHOW; m_t = 0;
                    end else begin
                        m_t++;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("mole_clk",      32'(bus.mole_clk),      32'(m_mode == M_SHOW));
            chk("busy",          32'(bus.busy),          32'(m_mode == M_SHOW || m_mode == M_GAP));
            chk("game_over",     32'(bus.game_over),     32'(m_mode == M_DONE));
            chk("active_moles",  32'(bus.active_moles),  32'(m_active));
            chk("score",         32'(bus.score),         m_score);
            chk("lives",         32'(bus.lives),         m_lives);
            chk("round",         32'(bus.round),         m_rnd);
            chk("wrong_presses", 32'(bus.wrong_presses), m_wrong);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_for(input logic level);
        int n;
        n = 0;
        while (bus.mole_clk !== level && n < 100) begin
            tick();
            n++;
        end
        chk("wait_mole_clk", 32'(bus.mole_clk), 32'(level));
    endtask

    task automatic measure(input logic level, output int n);
        n = 0;
        while (bus.mole_clk === level && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_mole_clk"},  32'(bus.mole_clk),      0);
        chk({tag, "_active"},    32'(bus.active_moles),  0);
        chk({tag, "_score"},     32'(bus.score),         0);
        chk({tag, "_lives"},     32'(bus.lives),         LV);
        chk({tag, "_round"},     32'(bus.round),         0);
        chk({tag, "_wrong"},     32'(bus.wrong_presses), 0);
        chk({tag, "_busy"},      32'(bus.busy),          0);
        chk({tag, "_game_over"}, 32'(bus.game_over),     0);
    endtask

    initial begin
        int n;
        int exp_len [9];
        exp_len = '{20, 5, 16, 5, 12, 5, 10, 5, 10};

        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.buttons = '0;
        bus.mole_positions = '0;
        tick(2);
        cmp_en = 1'b1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Full empty game: window shrinks 20,16,12 then clamps at 10.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            measure((i % 2 == 0) ? 1'b1 : 1'b0, n);
            chk($sformatf("phase%0d_len", i), n, exp_len[i]);
        end
        chk("g1_round",     32'(bus.round),     NR);
        chk("g1_game_over", 32'(bus.game_over), 1);
        chk("g1_lives",     32'(bus.lives),     LV);

        // Game 2: two hits, ignored presses, mixed hit/wrong, escapes to game over.
        bus.mole_positions = 18'h00005;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("g2_score_init", 32'(bus.score), 0);
        chk("g2_round_init", 32'(bus.round), 0);
        tick(3);
        chk("g2_capture", 32'(bus.active_moles), 32'h5);
        bus.buttons = 18'h00001;
        tick();
        chk("g2_hit1_score",  32'(bus.score),        1);
        chk("g2_hit1_active", 32'(bus.active_moles), 32'h4);
        bus.buttons = 18'h00005;
        tick();
        chk("g2_hit2_score",  32'(bus.score),        2);
        chk("g2_hit2_active", 32'(bus.active_moles), 0);
        bus.buttons = '0;
        wait_for(1'b0);
        chk("g2_r1_lives", 32'(bus.lives), LV);
        chk("g2_r1_round", 32'(bus.round), 1);

        bus.buttons = 18'h00003;
        tick();
        bus.buttons = '0;
        tick();
        chk("gap_press_score", 32'(bus.score),         2);
        chk("gap_press_wrong", 32'(bus.wrong_presses), 0);

        wait_for(1'b1);
        bus.mole_positions = 18'h00010;
        bus.buttons = 18'h00010;
        tick();
        bus.buttons = '0;
        tick(2);
        chk("early_press_active", 32'(bus.active_moles),  32'h10);
        chk("early_press_score",  32'(bus.score),         2);
        chk("early_press_wrong",  32'(bus.wrong_presses), 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_in_show_round", 32'(bus.round), 1);
        chk("start_in_show_score", 32'(bus.score), 2);

        bus.buttons = 18'h00290;
        tick();
        chk("mixed_score",  32'(bus.score),         3);
        chk("mixed_wrong",  32'(bus.wrong_presses), 1);
        chk("mixed_active", 32'(bus.active_moles),  0);
        tick(10);
        chk("held_score", 32'(bus.score),         3);
        chk("held_wrong", 32'(bus.wrong_presses), 1);
        bus.buttons = '0;
        wait_for(1'b0);
        chk("g2_r2_lives", 32'(bus.lives), LV);

        wait_for(1'b1);
        wait_for(1'b0);
        chk("escape1_lives", 32'(bus.lives),     LV - 1);
        chk("escape1_round", 32'(bus.round),     3);
        chk("escape1_go",    32'(bus.game_over), 0);
        wait_for(1'b1);
        wait_for(1'b0);
        chk("escape2_lives", 32'(bus.lives),     0);
        chk("escape2_round", 32'(bus.round),     4);
        chk("escape2_go",    32'(bus.game_over), 1);
        chk("escape2_busy",  32'(bus.busy),      0);
        tick(3);
        bus.buttons = 18'h00010;
        tick();
        bus.buttons = '0;
        tick();
        chk("done_frozen_score", 32'(bus.score),    3);
        chk("done_mole_clk",     32'(bus.mole_clk), 0);

        // Game 3: hit on the last up cycle, then reset mid-window.
        bus.mole_positions = 18'h00001;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("g3_score_init", 32'(bus.score), 0);
        chk("g3_lives_init", 32'(bus.lives), LV);
        tick(19);
        bus.buttons = 18'h00001;
        tick();
        bus.buttons = '0;
        chk("last_cycle_score", 32'(bus.score),    1);
        chk("last_cycle_lives", 32'(bus.lives),    LV);
        chk("last_cycle_round", 32'(bus.round),    1);
        chk("last_cycle_mclk",  32'(bus.mole_clk), 0);
        wait_for(1'b1);
        bus.mole_positions = 18'h00003;
        tick(3);
        bus.buttons = 18'h00003;
        tick();
        bus.buttons = '0;
        chk("pre_reset_score", 32'(bus.score), 3);
        rst_n = 1'b0;
        tick();
        check_reset_vals("midgame_reset");
        rst_n = 1'b1;
        tick();

        // Random play with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            rst_n     = ($urandom_range(0, 499) != 0);
            bus.start = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       bus.buttons = NH'($urandom);
                1:       bus.buttons = '0;
                2:       bus.buttons = bus.buttons;
                default: bus.buttons = bus.buttons | NH'(1 << $urandom_range(0, NH - 1));
            endcase
            bus.mole_positions = NH'($urandom) & NH'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end
endmodule
